// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state type, default slice count and 74181 function-select codes.
package alu_pkg;
    localparam int NIBBLES_DEFAULT = 4;
    localparam logic [3:0] S_A   = 4'b0000;
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_AM1 = 4'b1111;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu16_serial_ctrl_alu74181.sv
// alu74181: active-high-data 4-bit 74181 slice; carry pins use the active-low convention.
module alu74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn,
    output logic [3:0] f,
    output logic       cn4,
    output logic       eq
);
    logic [3:0] x, y;
    logic [4:0] sum;
    // Arithmetic is x + y + carry; logic mode is the carry-free XNOR of the same terms.
    assign x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    assign sum = {1'b0, x} + {1'b0, y} + {4'b0, ~cn};
    assign f   = m ? ~(x ^ y) : sum[3:0];
    assign cn4 = ~sum[4];
    assign eq  = &f;
endmodule

// File: rtl/alu16_serial_ctrl.sv
// alu16_serial_ctrl: runs one 74181 slice over NIBBLES nibbles, LSB first, then flags the result.
module alu16_serial_ctrl import alu_pkg::*; #(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic [3:0]           sel,
    input  logic                 mode,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 zero,
    output logic                 all_eq
);
    localparam int W  = 4*NIBBLES;
    localparam int IW = $clog2(NIBBLES+1);
    state_t state, next;
    logic [W-1:0] a_q, b_q;
    logic [3:0] s_q, f;
    logic m_q, carry, eq_acc, cn4, eq, last;
    logic [IW-1:0] idx;
    assign last = idx == IW'(NIBBLES);
    assign cout = carry;
    alu74181 u_alu (
        .a   (4'(a_q >> (4*idx))),
        .b   (4'(b_q >> (4*idx))),
        .s   (s_q),
        .m   (m_q),
        .cn  (carry),
        .f   (f),
        .cn4 (cn4),
        .eq  (eq)
    );
    always_comb begin
        next = (state == IDLE) ? (start ? RUN : IDLE) : (state == RUN) ? (last ? DONE : RUN) : IDLE;
        busy = state != IDLE;
        done = state == DONE;
    end
    // The extra RUN cycle at idx == NIBBLES settles zero/all_eq from the completed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            result <= '0;
            zero   <= 1'b0;
            all_eq <= 1'b0;
            carry  <= 1'b1;
            eq_acc <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && start) begin
                a_q    <= op_a;
                b_q    <= op_b;
                s_q    <= sel;
                m_q    <= mode;
                carry  <= cin;
                idx    <= '0;
                eq_acc <= 1'b1;
            end else if (state == RUN) begin
                if (last) begin
                    zero   <= result == '0;
                    all_eq <= eq_acc;
                end else begin
                    for (int j = 0; j < NIBBLES; j++)
                        if (idx == IW'(j)) result[4*j +: 4] <= f;
                    eq_acc <= eq_acc & eq;
                    carry  <= m_q ? carry : cn4;
                    idx    <= idx + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu16_serial_ctrl.sv
// tb_alu16_serial_ctrl: directed scenarios for the serial 74181 controller with hand-computed results.
module tb_alu16_serial_ctrl;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, mode = 1'b0, cin = 1'b1;
    logic [15:0] op_a = '0, op_b = '0, result;
    logic [3:0] sel = '0;
    logic busy, done, cout, zero, all_eq;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    alu16_serial_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .sel(sel),
        .mode(mode), .cin(cin), .busy(busy), .done(done), .result(result),
        .cout(cout), .zero(zero), .all_eq(all_eq)
    );
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic c, output int lat);
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
        op_a = a; op_b = b; sel = s; mode = m; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!done) lat = -1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({busy, done, result, cout, zero, all_eq} !== {2'b00, 16'h0000, 3'b100}) begin
            bad++;
            $display("FAIL reset got busy=%b done=%b result=%h cout=%b zero=%b all_eq=%b want 0 0 0000 1 0 0",
                     busy, done, result, cout, zero, all_eq);
        end
    endtask
    task automatic test_add;
        int lat;
        run_op(16'h1234, 16'h0011, S_ADD, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL add latency got %0d want 5", lat); end
        total++;
        if ({result, cout, zero, all_eq} !== {16'h1245, 3'b100}) begin
            bad++; $display("FAIL add outputs got %h/%b%b%b want 1245/100", result, cout, zero, all_eq);
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL add busy_in_done got %b want 1", busy); end
        @(posedge clk); #1;
        total++;
        if ({done, busy} !== 2'b00) begin bad++; $display("FAIL add done_width got done=%b busy=%b want 0 0", done, busy); end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({result, cout, zero, all_eq} !== {16'h1245, 3'b100}) begin
            bad++; $display("FAIL add hold got %h/%b%b%b want 1245/100", result, cout, zero, all_eq);
        end
    endtask
    task automatic test_ripple;
        int lat;
        run_op(16'h00FF, 16'h0001, S_ADD, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 5 || {result, cout, zero, all_eq} !== {16'h0100, 3'b100}) begin
            bad++; $display("FAIL ripple got lat=%0d %h/%b%b%b want 5 0100/100", lat, result, cout, zero, all_eq);
        end
        run_op(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 5 || {result, cout, zero, all_eq} !== {16'h0000, 3'b010}) begin
            bad++; $display("FAIL overflow got lat=%0d %h/%b%b%b want 5 0000/010", lat, result, cout, zero, all_eq);
        end
    endtask
    task automatic test_logic;
        int lat;
        run_op(16'h1234, 16'h0F0F, S_A, 1'b1, 1'b0, lat);
        total++;
        if (lat !== 5 || {result, cout, zero, all_eq} !== {16'hEDCB, 3'b000}) begin
            bad++; $display("FAIL logic_cin0 got lat=%0d %h/%b%b%b want 5 edcb/000", lat, result, cout, zero, all_eq);
        end
        run_op(16'h1234, 16'h0F0F, S_A, 1'b1, 1'b1, lat);
        total++;
        if (lat !== 5 || {result, cout, zero, all_eq} !== {16'hEDCB, 3'b100}) begin
            bad++; $display("FAIL logic_cin1 got lat=%0d %h/%b%b%b want 5 edcb/100", lat, result, cout, zero, all_eq);
        end
    endtask
    task automatic test_compare;
        int lat;
        run_op(16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 5 || {result, cout, zero, all_eq} !== {16'hFFFF, 3'b101}) begin
            bad++; $display("FAIL compare_eq got lat=%0d %h/%b%b%b want 5 ffff/101", lat, result, cout, zero, all_eq);
        end
        run_op(16'h5A5A, 16'h5A5B, S_SUB, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 5 || {result, cout, zero, all_eq} !== {16'hFFFE, 3'b100}) begin
            bad++; $display("FAIL compare_ne got lat=%0d %h/%b%b%b want 5 fffe/100", lat, result, cout, zero, all_eq);
        end
    endtask
    task automatic test_dec;
        int lat;
        run_op(16'h1000, 16'h0000, S_AM1, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 5 || {result, cout, zero, all_eq} !== {16'h0FFF, 3'b000}) begin
            bad++; $display("FAIL decrement got lat=%0d %h/%b%b%b want 5 0fff/000", lat, result, cout, zero, all_eq);
        end
    endtask
    task automatic test_start_busy;
        int lat;
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
        op_a = 16'h1234; op_b = 16'h0011; sel = S_ADD; mode = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        op_a = 16'hFFFF; op_b = 16'hFFFF; sel = S_A; mode = 1'b1; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        total++;
        if (!done || lat !== 5 || {result, cout, zero, all_eq} !== {16'h1245, 3'b100}) begin
            bad++; $display("FAIL start_busy got done=%b lat=%0d %h/%b%b%b want 1 5 1245/100",
                            done, lat, result, cout, zero, all_eq);
        end
    endtask
    task automatic test_reset_mid;
        int seen = 0;
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
        op_a = 16'h1234; op_b = 16'h0011; sel = S_ADD; mode = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({busy, done, result, cout} !== {2'b00, 16'h0000, 1'b1}) begin
            bad++; $display("FAIL reset_mid got busy=%b done=%b result=%h cout=%b want 0 0 0000 1",
                            busy, done, result, cout);
        end
        repeat (8) begin @(posedge clk); #1; if (done) seen++; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL reset_mid_no_done got %0d pulses want 0", seen); end
    endtask
    task automatic test_back_to_back;
        int lat;
        run_op(16'h00FF, 16'h0001, S_ADD, 1'b0, 1'b1, lat);
        total++;
        if (lat !== 5 || result !== 16'h0100) begin
            bad++; $display("FAIL b2b_first got lat=%0d result=%h want 5 0100", lat, result);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
        run_op(16'h1234, 16'h0011, S_ADD, 1'b0, 1'b0, lat);
        total++;
        if (lat !== 5 || {result, cout, zero, all_eq} !== {16'h1246, 3'b100}) begin
            bad++; $display("FAIL b2b_second got lat=%0d %h/%b%b%b want 5 1246/100", lat, result, cout, zero, all_eq);
        end
    endtask
    initial begin
        test_reset;
        test_add;
        test_ripple;
        test_logic;
        test_compare;
        test_dec;
        test_start_busy;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
